// File: rtl/lfsr_range_rng.sv
// Fibonacci-style LFSR with rejection sampling into 0..MAX_VALUE-1 and a valid/ready output register.
// One-cycle latency from an in-range candidate to rand_valid; the held sample is stable until accepted.
module lfsr_range_rng #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'hD008,
    parameter longint           MAX_VALUE = 18,
    parameter logic [WIDTH-1:0] SEED      = {{(WIDTH-1){1'b0}}, 1'b1},
    localparam int              OUT_W     = $clog2(MAX_VALUE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             rand_ready,
    output logic             rand_valid,
    output logic [OUT_W-1:0] rand_value,
    output logic             seed_zero,
    output logic [15:0]      reject_cnt
);

    typedef enum logic {FILL, VALID} state_t;

    // MAX_VALUE may be 2^WIDTH, so the range compare is done one bit wider than any lfsr slice
    localparam logic [32:0] MAX_EXT = 33'(MAX_VALUE);

    state_t           state, state_nx;
    logic [WIDTH-1:0] lfsr, lfsr_nx, lfsr_step;
    logic [OUT_W-1:0] cand, value_nx;
    logic [15:0]      rej_nx;
    logic             sz_nx, accept, in_range, lfsr_ok;

    assign lfsr_step  = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
    assign cand       = lfsr[OUT_W-1:0];
    assign in_range   = 33'(cand) < MAX_EXT;
    assign lfsr_ok    = (lfsr != '0);
    assign rand_valid = (state == VALID);
    assign accept     = rand_valid & rand_ready;

    always_comb begin
        state_nx = state;
        lfsr_nx  = lfsr;
        value_nx = rand_value;
        rej_nx   = reject_cnt;
        sz_nx    = 1'b0;
        if (seed_load) begin
            state_nx = FILL;
            if (seed_in == '0) begin
                lfsr_nx = SEED;
                sz_nx   = 1'b1;
            end else begin
                lfsr_nx = seed_in;
            end
        end else begin
            // a stuck-at-zero register is recovered even while frozen
            if (!lfsr_ok) begin
                lfsr_nx = SEED;
                sz_nx   = 1'b1;
            end else if (en) begin
                lfsr_nx = lfsr_step;
            end
            case (state)
                FILL: begin
                    if (en && lfsr_ok) begin
                        if (in_range) begin
                            value_nx = cand;
                            state_nx = VALID;
                        end else if (reject_cnt != 16'hFFFF) begin
                            rej_nx = reject_cnt + 16'd1;
                        end
                    end
                end
                VALID: begin
                    if (accept) begin
                        if (en && lfsr_ok && in_range) begin
                            value_nx = cand;
                        end else begin
                            state_nx = FILL;
                        end
                    end
                end
                default: state_nx = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FILL;
            lfsr       <= SEED;
            rand_value <= '0;
            reject_cnt <= '0;
            seed_zero  <= 1'b0;
        end else begin
            state      <= state_nx;
            lfsr       <= lfsr_nx;
            rand_value <= value_nx;
            reject_cnt <= rej_nx;
            seed_zero  <= sz_nx;
        end
    end

endmodule

// File: tb/tb_lfsr_range_rng.sv
// Directed bench for lfsr_range_rng with a cycle model feeding a sample scoreboard.
module tb_lfsr_range_rng;

    logic        clk = 1'b0;
    logic        rst_n, en, seed_load, rand_ready;
    logic [15:0] seed_in;
    logic        rand_valid, seed_zero;
    logic [4:0]  rand_value;
    logic [15:0] reject_cnt;

    int n_pass = 0;
    int n_total = 0;

    // reference state
    logic [15:0] m_lfsr;
    logic        m_valid, m_sz;
    logic [15:0] m_rej;
    logic [4:0]  sb[$];

    always #5 clk = ~clk;

    lfsr_range_rng dut (
        .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .rand_ready(rand_ready), .rand_valid(rand_valid), .rand_value(rand_value),
        .seed_zero(seed_zero), .reject_cnt(reject_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance the model and DUT one edge; inputs are read as driven before the edge.
    task automatic tick();
        logic       acc, inr;
        logic [4:0] cand;
        acc  = m_valid && rand_ready;
        cand = m_lfsr[4:0];
        inr  = cand < 5'd18;
        m_sz = 1'b0;
        if (!rst_n) begin
            m_lfsr = 16'd1; m_valid = 1'b0; m_rej = '0; sb.delete();
        end else if (seed_load) begin
            m_lfsr  = (seed_in == 16'd0) ? 16'd1 : seed_in;
            m_sz    = (seed_in == 16'd0);
            m_valid = 1'b0;
            sb.delete();
        end else begin
            if (acc) begin
                if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
                else chk("accepted_value", rand_value, sb.pop_front());
            end
            if (!m_valid) begin
                if (en) begin
                    if (inr) begin sb.push_back(cand); m_valid = 1'b1; end
                    else if (m_rej != 16'hFFFF) m_rej = m_rej + 16'd1;
                end
            end else if (acc) begin
                if (en && inr) sb.push_back(cand);
                else m_valid = 1'b0;
            end
            if (en) m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hD008)};
        end
        @(posedge clk);
        @(negedge clk);
        chk("rand_valid", rand_valid, m_valid);
        chk("seed_zero", seed_zero, m_sz);
        chk("reject_cnt", reject_cnt, m_rej);
        if (m_valid && sb.size() != 0) chk("held_value", rand_value, sb[0]);
    endtask

    initial begin
        int exp35[9] = '{1, 2, 4, 8, 17, 2, 4, 8, 17};
        int exp40[3] = '{1, 2, 4};
        logic [4:0] held;
        m_lfsr = 16'd1; m_valid = 1'b0; m_sz = 1'b0; m_rej = '0;
        rst_n = 1'b0; en = 1'b1; seed_load = 1'b1; seed_in = 16'h0; rand_ready = 1'b1;
        @(negedge clk);
        tick();
        chk("reset_valid", rand_valid, 32'd0);
        chk("reset_value", rand_value, 32'd0);
        chk("reset_rej", reject_cnt, 32'd0);
        chk("reset_sz", seed_zero, 32'd0);
        rst_n = 1'b1; seed_load = 1'b0;

        // free-running stream with ready held
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("stream_valid", rand_valid, 32'd1);
            chk("stream_value", rand_value, 32'(exp35[i]));
        end
        chk("stream_rej", reject_cnt, 32'd0);

        // seed 0x13: candidate 19 rejected, then 6
        seed_load = 1'b1; seed_in = 16'h0013;
        tick();
        chk("load_drops_valid", rand_valid, 32'd0);
        seed_load = 1'b0;
        tick();
        chk("seed13_reject", reject_cnt, 32'd1);
        chk("seed13_valid_lo", rand_valid, 32'd0);
        tick();
        chk("seed13_valid", rand_valid, 32'd1);
        chk("seed13_value", rand_value, 32'd6);

        // zero seed falls back to SEED
        seed_load = 1'b1; seed_in = 16'h0000;
        tick();
        chk("zero_seed_pulse", seed_zero, 32'd1);
        seed_load = 1'b0;
        tick();
        chk("zero_seed_pulse_end", seed_zero, 32'd0);
        chk("zero_seed_value", rand_value, 32'd1);
        chk("zero_seed_valid", rand_valid, 32'd1);

        // backpressure hold
        rand_ready = 1'b0;
        held = rand_value;
        for (int i = 0; i < 10; i++) tick();
        chk("bp_hold", rand_value, held);
        rand_ready = 1'b1;
        tick();
        tick();

        // consume with en low
        en = 1'b0; rand_ready = 1'b0;
        tick();
        chk("en0_still_valid", rand_valid, 32'd1);
        rand_ready = 1'b1;
        tick();
        chk("en0_consumed", rand_valid, 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("en0_no_new", rand_valid, 32'd0);

        // reset mid-stream
        en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        chk("midreset_valid", rand_valid, 32'd0);
        chk("midreset_rej", reject_cnt, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("restart_value", rand_value, 32'(exp40[i]));
        end

        // random mix of ready/en against the model
        for (int i = 0; i < 200; i++) begin
            rand_ready = 1'($urandom_range(0, 1));
            en         = ($urandom_range(0, 3) != 0);
            seed_load  = ($urandom_range(0, 31) == 0);
            seed_in    = 16'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 65535));
            tick();
        end
        seed_load = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
